// File: rtl/argon_regfile_sequencer.sv
// Register-file access sequencer: turns one operand-read or writeback request into the
// ordered LATCHSEL/READA/READB/LATCHC command stream. Optional macro: ARGON_RFSEQ_SELCACHE_EN.
package regfile_pkg;
    localparam logic [3:0] COM_NOP      = 4'd0;
    localparam logic [3:0] COM_LATCHSEL = 4'd1;
    localparam logic [3:0] COM_READA    = 4'd2;
    localparam logic [3:0] COM_READB    = 4'd3;
    localparam logic [3:0] COM_LATCHC   = 4'd4;
endpackage

module argon_regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int                   WORD_WIDTH  = 16,
    parameter int                   INDEX_WIDTH = 3,
    parameter int                   CMD_WIDTH   = 4,
    parameter logic [CMD_WIDTH-1:0] CMD_IDLE    = '0
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_write,
    input  logic [INDEX_WIDTH-1:0] i_req_idx_a,
    input  logic [INDEX_WIDTH-1:0] i_req_idx_b,
    input  logic [INDEX_WIDTH-1:0] i_req_idx_c,
    input  logic [WORD_WIDTH-1:0]  i_req_wdata,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [WORD_WIDTH-1:0]  o_rsp_a,
    output logic [WORD_WIDTH-1:0]  o_rsp_b,
    output logic                   o_rsp_err,
    output logic                   o_rf_valid,
    output logic [CMD_WIDTH-1:0]   o_rf_command,
    output logic [WORD_WIDTH-1:0]  o_rf_data,
    input  logic                   i_rf_valid,
    input  logic [WORD_WIDTH-1:0]  i_rf_data,
    output logic                   o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_RDA,
        S_RDB,
        S_RSP,
        S_WRC
    } state_e;

    state_e                 state_q, state_d;
    logic                   write_q;
    logic [INDEX_WIDTH-1:0] idxA_q, idxB_q, idxC_q;
    logic [WORD_WIDTH-1:0]  wdata_q;
    logic [WORD_WIDTH-1:0]  rspA_q, rspB_q;
    logic                   err_q;
    logic                   skipSel;
    logic                   accept;

    assign accept = i_req_valid && o_req_ready;

`ifdef ARGON_RFSEQ_SELCACHE_EN
    // Mirrors the register file's latched selection so a repeated selection can skip SEL.
    logic [INDEX_WIDTH-1:0] cacheA_q, cacheB_q, cacheC_q;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            cacheA_q <= '0;
            cacheB_q <= '0;
            cacheC_q <= '0;
        end else if (state_q == S_SEL) begin
            cacheA_q <= idxA_q;
            cacheB_q <= idxB_q;
            cacheC_q <= idxC_q;
        end
    end

    assign skipSel = i_req_write ? (i_req_idx_c == cacheC_q)
                                 : ((i_req_idx_a == cacheA_q) && (i_req_idx_b == cacheB_q));
`else
    assign skipSel = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            idxA_q  <= '0;
            idxB_q  <= '0;
            idxC_q  <= '0;
            wdata_q <= '0;
            rspA_q  <= '0;
            rspB_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= i_req_write;
                idxA_q  <= i_req_idx_a;
                idxB_q  <= i_req_idx_b;
                idxC_q  <= i_req_idx_c;
                wdata_q <= i_req_wdata;
                err_q   <= 1'b0;
            end
            if (state_q == S_RDA) begin
                rspA_q <= i_rf_data;
                if (!i_rf_valid) err_q <= 1'b1;
            end
            if (state_q == S_RDB) begin
                rspB_q <= i_rf_data;
                if (!i_rf_valid) err_q <= 1'b1;
            end
            if ((state_q == S_RSP) && i_rsp_ready) err_q <= 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        o_req_ready  = 1'b0;
        o_rsp_valid  = 1'b0;
        o_rf_valid   = 1'b0;
        o_rf_command = CMD_IDLE;
        o_rf_data    = '0;
        case (state_q)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (skipSel) state_d = i_req_write ? S_WRC : S_RDA;
                    else         state_d = S_SEL;
                end
            end
            S_SEL: begin
                o_rf_command = CMD_WIDTH'(COM_LATCHSEL);
                o_rf_valid   = 1'b1;
                o_rf_data    = WORD_WIDTH'({idxC_q, idxB_q, idxA_q});
                state_d      = write_q ? S_WRC : S_RDA;
            end
            S_RDA: begin
                o_rf_command = CMD_WIDTH'(COM_READA);
                state_d      = S_RDB;
            end
            S_RDB: begin
                o_rf_command = CMD_WIDTH'(COM_READB);
                state_d      = S_RSP;
            end
            S_RSP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_d = S_IDLE;
            end
            S_WRC: begin
                o_rf_command = CMD_WIDTH'(COM_LATCHC);
                o_rf_valid   = 1'b1;
                o_rf_data    = wdata_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rsp_a   = rspA_q;
    assign o_rsp_b   = rspB_q;
    assign o_rsp_err = err_q;
    assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_argon_regfile_sequencer.sv
// Directed bench for argon_regfile_sequencer with a behavioural register-file stub;
// expected latencies follow ARGON_RFSEQ_SELCACHE_EN when it is defined.
module tb_argon_regfile_sequencer;
    import regfile_pkg::*;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_write;
    logic [2:0]  i_req_idx_a, i_req_idx_b, i_req_idx_c;
    logic [15:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [15:0] o_rsp_a, o_rsp_b;
    logic        o_rsp_err;
    logic        o_rf_valid;
    logic [3:0]  o_rf_command;
    logic [15:0] o_rf_data;
    logic        i_rf_valid;
    logic [15:0] i_rf_data;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    argon_regfile_sequencer dut (
        .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
        .i_req_idx_a(i_req_idx_a), .i_req_idx_b(i_req_idx_b), .i_req_idx_c(i_req_idx_c),
        .i_req_wdata(i_req_wdata), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_a(o_rsp_a), .o_rsp_b(o_rsp_b), .o_rsp_err(o_rsp_err),
        .o_rf_valid(o_rf_valid), .o_rf_command(o_rf_command), .o_rf_data(o_rf_data),
        .i_rf_valid(i_rf_valid), .i_rf_data(i_rf_data), .o_busy(o_busy)
    );

    always #5 i_Clk = ~i_Clk;

    // Register-file stub: latches the selection, reads combinationally, r0 discards writes.
    logic [15:0] rfMem [8];
    logic [2:0]  rfSelA, rfSelB, rfSelC;
    logic        errInjB;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rfSelA <= '0;
            rfSelB <= '0;
            rfSelC <= '0;
            for (int r = 0; r < 8; r++) rfMem[r] <= 16'(r * 16'h1111);
            rfMem[2] <= 16'h1234;
            rfMem[3] <= 16'hBEEF;
        end else if (o_rf_valid) begin
            if (o_rf_command == COM_LATCHSEL) begin
                rfSelA <= o_rf_data[2:0];
                rfSelB <= o_rf_data[5:3];
                rfSelC <= o_rf_data[8:6];
            end else if (o_rf_command == COM_LATCHC && rfSelC != 3'd0) begin
                rfMem[rfSelC] <= o_rf_data;
            end
        end
    end

    always_comb begin
        i_rf_data  = '0;
        i_rf_valid = !(errInjB && o_rf_command == COM_READB);
        if (o_rf_command == COM_READA)      i_rf_data = rfMem[rfSelA];
        else if (o_rf_command == COM_READB) i_rf_data = rfMem[rfSelB];
    end

    typedef struct {
        logic        write;
        logic [2:0]  idxA, idxB, idxC;
        logic [15:0] wdata;
        logic        errB;
        int          hold;
        logic [15:0] expA, expB;
        logic        expErr;
    } vec_t;

    vec_t vecs [12];
    logic [2:0] mA = '0, mB = '0, mC = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " req_ready"}, 32'(o_req_ready), 32'd1);
        checkOutput({tag, " busy"}, 32'(o_busy), 32'd0);
        checkOutput({tag, " rf_command"}, 32'(o_rf_command), 32'(COM_NOP));
        checkOutput({tag, " rf_valid"}, 32'(o_rf_valid), 32'd0);
        checkOutput({tag, " rf_data"}, 32'(o_rf_data), 32'd0);
        checkOutput({tag, " rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    endtask

    // Runs one full transaction and checks every cycle of its command stream.
    task automatic applyStimulus(input int id, input vec_t v);
        string tag;
        logic  skip;
        tag = $sformatf("v%0d", id);
        skip = 1'b0;
`ifdef ARGON_RFSEQ_SELCACHE_EN
        skip = v.write ? (v.idxC == mC) : (v.idxA == mA && v.idxB == mB);
`endif
        @(negedge i_Clk);
        i_req_valid = 1'b1;
        i_req_write = v.write;
        i_req_idx_a = v.idxA;
        i_req_idx_b = v.idxB;
        i_req_idx_c = v.idxC;
        i_req_wdata = v.wdata;
        errInjB     = v.errB;
        checkOutput({tag, " req_ready before"}, 32'(o_req_ready), 32'd1);
        @(posedge i_Clk);
        #1;
        i_req_valid = 1'b0;
        if (!skip) begin
            @(negedge i_Clk);
            checkOutput({tag, " sel cmd"}, 32'(o_rf_command), 32'(COM_LATCHSEL));
            checkOutput({tag, " sel valid"}, 32'(o_rf_valid), 32'd1);
            checkOutput({tag, " sel data"}, 32'(o_rf_data), 32'({v.idxC, v.idxB, v.idxA}));
            checkOutput({tag, " sel req_ready"}, 32'(o_req_ready), 32'd0);
            mA = v.idxA;
            mB = v.idxB;
            mC = v.idxC;
        end
        if (!v.write) begin
            @(negedge i_Clk);
            checkOutput({tag, " rda cmd"}, 32'(o_rf_command), 32'(COM_READA));
            checkOutput({tag, " rda valid"}, 32'(o_rf_valid), 32'd0);
            @(negedge i_Clk);
            checkOutput({tag, " rdb cmd"}, 32'(o_rf_command), 32'(COM_READB));
            @(negedge i_Clk);
            checkOutput({tag, " rsp_valid"}, 32'(o_rsp_valid), 32'd1);
            checkOutput({tag, " rsp_a"}, 32'(o_rsp_a), 32'(v.expA));
            checkOutput({tag, " rsp_b"}, 32'(o_rsp_b), 32'(v.expB));
            checkOutput({tag, " rsp_err"}, 32'(o_rsp_err), 32'(v.expErr));
            for (int k = 0; k < v.hold; k++) begin
                i_req_valid = 1'b1;
                i_req_write = 1'b1;
                i_req_idx_c = 3'(k);
                @(negedge i_Clk);
                checkOutput({tag, " hold rsp_valid"}, 32'(o_rsp_valid), 32'd1);
                checkOutput({tag, " hold rsp_a"}, 32'(o_rsp_a), 32'(v.expA));
                checkOutput({tag, " hold rsp_b"}, 32'(o_rsp_b), 32'(v.expB));
                checkOutput({tag, " hold req_ready"}, 32'(o_req_ready), 32'd0);
                checkOutput({tag, " hold rf_command"}, 32'(o_rf_command), 32'(COM_NOP));
                checkOutput({tag, " hold rf_valid"}, 32'(o_rf_valid), 32'd0);
            end
            i_req_valid = 1'b0;
            i_rsp_ready = 1'b1;
            @(posedge i_Clk);
            #1;
            i_rsp_ready = 1'b0;
            @(negedge i_Clk);
            checkOutput({tag, " after rsp_valid"}, 32'(o_rsp_valid), 32'd0);
            checkOutput({tag, " after rsp_err"}, 32'(o_rsp_err), 32'd0);
            checkOutput({tag, " after req_ready"}, 32'(o_req_ready), 32'd1);
        end else begin
            @(negedge i_Clk);
            checkOutput({tag, " wrc cmd"}, 32'(o_rf_command), 32'(COM_LATCHC));
            checkOutput({tag, " wrc valid"}, 32'(o_rf_valid), 32'd1);
            checkOutput({tag, " wrc data"}, 32'(o_rf_data), 32'(v.wdata));
            checkOutput({tag, " wrc rsp_valid"}, 32'(o_rsp_valid), 32'd0);
            @(negedge i_Clk);
            checkOutput({tag, " after req_ready"}, 32'(o_req_ready), 32'd1);
            checkOutput({tag, " after rf_command"}, 32'(o_rf_command), 32'(COM_NOP));
        end
        errInjB = 1'b0;
    endtask

    initial begin
        //            write idxA  idxB  idxC  wdata     errB  hold expA      expB      expErr
        vecs[0]  = '{1'b0, 3'd2, 3'd3, 3'd0, 16'h0000, 1'b0, 0, 16'h1234, 16'hBEEF, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 3'd0, 3'd5, 16'hA5A5, 1'b0, 0, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 3'd5, 3'd0, 3'd0, 16'h0000, 1'b0, 0, 16'hA5A5, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b0, 0, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 3'd2, 3'd3, 16'h0000, 1'b0, 0, 16'h0000, 16'h1234, 1'b0};
        vecs[5]  = '{1'b0, 3'd7, 3'd1, 3'd6, 16'h0000, 1'b0, 0, 16'h7777, 16'h1111, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 3'd0, 3'd7, 16'h0F0F, 1'b0, 0, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 3'd7, 3'd7, 3'd0, 16'h0000, 1'b0, 0, 16'h0F0F, 16'h0F0F, 1'b0};
        vecs[8]  = '{1'b0, 3'd6, 3'd3, 3'd0, 16'h0000, 1'b1, 0, 16'h6666, 16'hBEEF, 1'b1};
        vecs[9]  = '{1'b0, 3'd1, 3'd4, 3'd0, 16'h0000, 1'b0, 5, 16'h1111, 16'h4444, 1'b0};
        vecs[10] = '{1'b0, 3'd1, 3'd4, 3'd0, 16'h0000, 1'b0, 0, 16'h1111, 16'h4444, 1'b0};
        vecs[11] = '{1'b0, 3'd2, 3'd3, 3'd1, 16'h0000, 1'b0, 0, 16'h1234, 16'hBEEF, 1'b0};

        i_Reset_n   = 1'b0;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_idx_a = '0;
        i_req_idx_b = '0;
        i_req_idx_c = '0;
        i_req_wdata = '0;
        i_rsp_ready = 1'b0;
        errInjB     = 1'b0;

        @(negedge i_Clk);
        checkIdleOutputs("reset");
        checkOutput("reset rsp_a", 32'(o_rsp_a), 32'd0);
        checkOutput("reset rsp_err", 32'(o_rsp_err), 32'd0);
        @(posedge i_Clk);
        #1;
        i_Reset_n = 1'b1;

        for (int i = 0; i < 11; i++) applyStimulus(i, vecs[i]);

        // Reset while in RDA: sequence abandoned, outputs fall back asynchronously.
        @(negedge i_Clk);
        i_req_valid = 1'b1;
        i_req_write = 1'b0;
        i_req_idx_a = 3'd2;
        i_req_idx_b = 3'd3;
        i_req_idx_c = 3'd1;
        @(posedge i_Clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge i_Clk);
        checkOutput("rst seq sel cmd", 32'(o_rf_command), 32'(COM_LATCHSEL));
        @(posedge i_Clk);
        #2;
        checkOutput("rst seq rda cmd", 32'(o_rf_command), 32'(COM_READA));
        i_Reset_n = 1'b0;
        #1;
        checkIdleOutputs("midreset");
        checkOutput("midreset rsp_a", 32'(o_rsp_a), 32'd0);
        checkOutput("midreset rsp_b", 32'(o_rsp_b), 32'd0);
        @(negedge i_Clk);
        checkOutput("midreset held cmd", 32'(o_rf_command), 32'(COM_NOP));
        @(posedge i_Clk);
        #1;
        i_Reset_n = 1'b1;
        mA = '0;
        mB = '0;
        mC = '0;
        applyStimulus(11, vecs[11]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/argon_regfile_sequencer.md
Name: argon_regfile_sequencer

Overview:
- Sequences register-file accesses on behalf of a single upstream requester (decode/execute stage).
- Translates one operand-fetch or writeback request into the ordered register-file command stream:
  - read: LATCHSEL, READA, READB
  - write: LATCHSEL, LATCHC
- Captures operands and returns them over a valid/ready response channel.
- Sits between the core control FSM and the register file's bus interface.

Parameters:
- WORD_WIDTH, 16, datapath word width.
- INDEX_WIDTH, 3, register index width (8 registers, r0 reads as zero).
- CMD_WIDTH, 4, register-file command field width.
- CMD_IDLE, 0, command driven when no access is in progress; must decode as no-op in the register file.

Ports:
- i_Clk  in  1  clock.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  sequencer can accept a request.
- i_req_write  in  1  1 = writeback of i_req_wdata to idx_c; 0 = operand read of idx_a/idx_b.
- i_req_idx_a  in  INDEX_WIDTH  source A index.
- i_req_idx_b  in  INDEX_WIDTH  source B index.
- i_req_idx_c  in  INDEX_WIDTH  destination index.
- i_req_wdata  in  WORD_WIDTH  writeback data.
- o_rsp_valid  out  1  operand response valid.
- i_rsp_ready  in  1  response accepted.
- o_rsp_a  out  WORD_WIDTH  operand A.
- o_rsp_b  out  WORD_WIDTH  operand B.
- o_rsp_err  out  1  a read cycle saw i_rf_valid low.
- o_rf_valid  out  1  register-file write strobe.
- o_rf_command  out  CMD_WIDTH  register-file command.
- o_rf_data  out  WORD_WIDTH  register-file write data.
- i_rf_valid  in  1  register-file read valid (combinational on command).
- i_rf_data  in  WORD_WIDTH  register-file read data.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - All outputs 0, except o_rf_command = CMD_IDLE and o_req_ready = 1.
  - Captured request and operand registers = 0.
  - Selection cache = {0,0,0}, matching register-file index reset.
- Reset asserted mid-sequence: the sequence is abandoned immediately and no further register-file commands are issued.
- Request handshake: a request is accepted on a clock edge where i_req_valid && o_req_ready. o_req_ready = 1 only in IDLE. Request fields are registered at acceptance.
- States: IDLE, SEL, RDA, RDB, RSP, WRC.
- SEL:
  - o_rf_command = COM_LATCHSEL, o_rf_valid = 1.
  - o_rf_data = zero-extended {idx_c, idx_b, idx_a}, with A in bits [INDEX_WIDTH-1:0].
  - Next state: RDA if read, WRC if write.
- RDA:
  - o_rf_command = COM_READA, o_rf_valid = 0.
  - Capture i_rf_data into o_rsp_a at the end of the cycle.
  - If i_rf_valid == 0, set the err flag.
  - Next state: RDB.
- RDB: same as RDA, using COM_READB, capturing into o_rsp_b. Next state: RSP.
- RSP:
  - o_rsp_valid = 1; o_rsp_a, o_rsp_b and o_rsp_err are held stable.
  - On i_rsp_ready → IDLE, and err clears.
  - No new request is accepted while in RSP.
- WRC:
  - o_rf_command = COM_LATCHC, o_rf_valid = 1, o_rf_data = wdata.
  - Next state: IDLE. No response is generated for writes.
  - idx_c == 0 still runs the full sequence; the register file discards the write.
- IDLE: o_rf_command = CMD_IDLE, o_rf_valid = 0, o_rf_data = 0.
- Latency (acceptance edge = cycle 0, no cache):
  - Read: SEL in cycle 1, RDA in 2, RDB in 3, o_rsp_valid from cycle 4.
  - Write: SEL in 1, WRC in 2, o_req_ready high again in 3.
- Throughput: at most one request in flight.
- Command encodings (COM_*) come from regfile_pkg.

Optional Feature:
- Macro: ARGON_RFSEQ_SELCACHE_EN.
- Enabled:
  - The sequencer keeps the last issued selection {c,b,a}.
  - If the accepted request's relevant indices all match the cache, SEL is skipped. Read requests compare a and b; write requests compare c.
  - Skip paths: IDLE → RDA (read), IDLE → WRC (write). This saves one cycle.
  - The cache updates only when SEL is issued and resets to {0,0,0}.
- Disabled: SEL is always issued, the cache logic is absent, and latency is exactly as listed above.

Test Plan:
- Read request a=2, b=3, stub register file holding r2=0x1234, r3=0xBEEF:
  - Cycle 1: COM_LATCHSEL with o_rf_data[8:0] = {c,3,2}.
  - Cycles 2-3: COM_READA, COM_READB.
  - Cycle 4: o_rsp_valid = 1, o_rsp_a = 0x1234, o_rsp_b = 0xBEEF, o_rsp_err = 0.
- Write request c=5, wdata=0xA5A5:
  - Cycle 1: SEL; cycle 2: COM_LATCHC with o_rf_valid = 1 and data 0xA5A5.
  - o_req_ready = 1 in cycle 3.
  - A following read a=5 returns 0xA5A5.
- Back-pressure: hold i_rsp_ready = 0 for 5 cycles → o_rsp_valid stays 1 with data stable; o_req_ready stays 0; no register-file commands issued (o_rf_command = CMD_IDLE).
- Error: stub drives i_rf_valid = 0 during READB → o_rsp_err = 1 in RSP, and it clears after the handshake.
- Reset: drive i_Reset_n low during RDA → outputs return to reset values asynchronously; after release, a new read completes with correct data.
- Cache (with ARGON_RFSEQ_SELCACHE_EN): two consecutive reads a=1, b=4 → the second skips SEL, with o_rsp_valid 3 cycles after acceptance. Without the macro, both take 4 cycles.
